// File: rtl/snes_joy_port_device.sv
// Peripheral side of a SNES controller port: a 12-button pad or a 4-player multitap.
// It shifts latched button words serially onto JOY_DI under console STRB/CLK/P6 control.
module snes_joy_port_device #(
  parameter int SYNC_STAGES = 2,
  parameter bit MULTITAP_EN = 1'b1
) (
  input  logic        MCLK,
  input  logic        RESET_N,
  input  logic [1:0]  MODE,
  input  logic [11:0] PAD_A,
  input  logic [11:0] PAD_B,
  input  logic [11:0] PAD_C,
  input  logic [11:0] PAD_D,
  input  logic        JOY_STRB,
  input  logic        JOY_CLK,
  input  logic        JOY_P6,
  output logic [1:0]  JOY_DI,
  output logic        LATCH_PULSE
);

  logic [SYNC_STAGES-1:0] r_strb_sync;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_p6_sync;
  logic                   r_strb_d;
  logic                   r_clk_d;
  logic                   r_p6_d;

  logic        w_strb;
  logic        w_clk;
  logic        w_p6;
  logic        w_clk_rise;
  logic        w_strb_fall;
  logic        w_mode_pad;
  logic        w_mode_tap;
  logic        w_sel_ab;
  logic        w_shift_ab;
  logic        w_shift_cd;
  logic        w_sr_c0;
  logic        w_sr_d0;
  logic [1:0]  w_di_next;

  logic [15:0] r_sr_a;
  logic [15:0] r_sr_b;
  logic [4:0]  r_cnt_a;
  logic [4:0]  r_cnt_b;
  logic [1:0]  r_joy_di;
  logic        r_latch_pulse;

  always_ff @(posedge MCLK) begin
    if (!RESET_N) begin
      r_strb_sync <= '0;
      r_clk_sync  <= '0;
      r_p6_sync   <= '0;
      r_strb_d    <= 1'b0;
      r_clk_d     <= 1'b0;
      r_p6_d      <= 1'b0;
    end else begin
      r_strb_sync <= {r_strb_sync[SYNC_STAGES-2:0], JOY_STRB};
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], JOY_CLK};
      r_p6_sync   <= {r_p6_sync[SYNC_STAGES-2:0], JOY_P6};
      r_strb_d    <= w_strb;
      r_clk_d     <= w_clk;
      r_p6_d      <= w_p6;
    end
  end

  assign w_strb      = r_strb_sync[SYNC_STAGES-1];
  assign w_clk       = r_clk_sync[SYNC_STAGES-1];
  assign w_p6        = r_p6_sync[SYNC_STAGES-1];
  assign w_clk_rise  = w_clk & ~r_clk_d;
  assign w_strb_fall = ~w_strb & r_strb_d;

  assign w_mode_tap  = (MODE == 2'd2) && MULTITAP_EN;
  assign w_mode_pad  = (MODE == 2'd1) || ((MODE == 2'd2) && !MULTITAP_EN);
  assign w_sel_ab    = ~w_mode_tap | w_p6;
  assign w_shift_ab  = w_clk_rise & ~w_strb & w_sel_ab;
  assign w_shift_cd  = w_clk_rise & ~w_strb & ~w_sel_ab;

  // Latch wins over a coincident clock edge; counters saturate at 16 so the word stays all ones.
  always_ff @(posedge MCLK) begin
    if (!RESET_N) begin
      r_sr_a  <= '0;
      r_sr_b  <= '0;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (w_strb) begin
      r_sr_a  <= {4'b0000, PAD_A};
      r_sr_b  <= {4'b0000, PAD_B};
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (w_shift_ab) begin
      if (r_cnt_a != 5'd16) begin
        r_sr_a  <= {1'b1, r_sr_a[15:1]};
        r_cnt_a <= r_cnt_a + 5'd1;
      end
      if (r_cnt_b != 5'd16) begin
        r_sr_b  <= {1'b1, r_sr_b[15:1]};
        r_cnt_b <= r_cnt_b + 5'd1;
      end
    end
  end

  generate
    if (MULTITAP_EN) begin : g_tap
      logic [15:0] r_sr_c;
      logic [15:0] r_sr_d;
      logic [4:0]  r_cnt_c;
      logic [4:0]  r_cnt_d;

      always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
          r_sr_c  <= '0;
          r_sr_d  <= '0;
          r_cnt_c <= '0;
          r_cnt_d <= '0;
        end else if (w_strb) begin
          r_sr_c  <= {4'b0000, PAD_C};
          r_sr_d  <= {4'b0000, PAD_D};
          r_cnt_c <= '0;
          r_cnt_d <= '0;
        end else if (w_shift_cd) begin
          if (r_cnt_c != 5'd16) begin
            r_sr_c  <= {1'b1, r_sr_c[15:1]};
            r_cnt_c <= r_cnt_c + 5'd1;
          end
          if (r_cnt_d != 5'd16) begin
            r_sr_d  <= {1'b1, r_sr_d[15:1]};
            r_cnt_d <= r_cnt_d + 5'd1;
          end
        end
      end

      assign w_sr_c0 = r_sr_c[0];
      assign w_sr_d0 = r_sr_d[0];
    end else begin : g_no_tap
      assign w_sr_c0 = 1'b0;
      assign w_sr_d0 = 1'b0;
    end
  endgenerate

  // Delayed STRB/P6 copies keep every pin at the same SYNC_STAGES+2 latency to JOY_DI.
  always_comb begin
    w_di_next = 2'b00;
    if (w_mode_tap) begin
      if (r_strb_d)
        w_di_next = {1'b1, r_sr_a[0]};
      else if (r_p6_d)
        w_di_next = {r_sr_b[0], r_sr_a[0]};
      else
        w_di_next = {w_sr_d0, w_sr_c0};
    end else if (w_mode_pad) begin
      w_di_next = {1'b0, r_sr_a[0]};
    end
  end

  always_ff @(posedge MCLK) begin
    if (!RESET_N) begin
      r_joy_di      <= 2'b00;
      r_latch_pulse <= 1'b0;
    end else begin
      r_joy_di      <= w_di_next;
      r_latch_pulse <= w_strb_fall;
    end
  end

  assign JOY_DI      = r_joy_di;
  assign LATCH_PULSE = r_latch_pulse;

endmodule
